// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types, forwarding-select encodings and hazard helper functions
// for the MIPS hazard/forwarding controller.
package hazard_fwd_ctrl_pkg;

    localparam int TNEW_W = 2;

    typedef logic [4:0]        reg_addr_t;
    typedef logic [TNEW_W-1:0] tnew_t;
    typedef logic [1:0]        fw_sel_t;

    localparam fw_sel_t FW_NONE   = 2'b00;
    localparam fw_sel_t FW_W      = 2'b01;
    localparam fw_sel_t FW_M      = 2'b10;
    localparam tnew_t   TUSE_NONE = 2'd3;

    typedef struct packed {
        reg_addr_t rs;
        reg_addr_t rt;
        reg_addr_t wa;
        tnew_t     tnew;
    } e_tag_t;

    // M wins over W; a result still being computed in M is not forwardable.
    function automatic fw_sel_t fwdSelect(input reg_addr_t addr,
                                          input reg_addr_t mWa,
                                          input tnew_t     mTnew,
                                          input reg_addr_t wWa);
        fw_sel_t sel;
        sel = FW_NONE;
        if (addr != '0) begin
            if (mWa == addr && mTnew == '0) begin
                sel = FW_M;
            end else if (wWa == addr) begin
                sel = FW_W;
            end
        end
        return sel;
    endfunction

    function automatic logic rawHazard(input reg_addr_t addr,
                                       input tnew_t     tuse,
                                       input reg_addr_t wa,
                                       input tnew_t     tnew);
        return (addr != '0) && (tuse != TUSE_NONE) && (addr == wa) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline-side view of the hazard controller: D-stage operand info in,
// stall and operand-mux selects out.
interface hazard_fwd_ctrl_if;
    import hazard_fwd_ctrl_pkg::*;

    logic      flush;
    reg_addr_t D_rs;
    reg_addr_t D_rt;
    tnew_t     D_Tuse_rs;
    tnew_t     D_Tuse_rt;
    reg_addr_t D_wa;
    tnew_t     D_Tnew;
    logic      D_md_use;
    logic      E_md_start;
    logic      E_md_div;

    logic      stall;
    fw_sel_t   D_fw_rs;
    fw_sel_t   D_fw_rt;
    fw_sel_t   E_fw_rs;
    fw_sel_t   E_fw_rt;
    logic      md_busy;

    modport master (
        output flush, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_wa, D_Tnew,
               D_md_use, E_md_start, E_md_div,
        input  stall, D_fw_rs, D_fw_rt, E_fw_rs, E_fw_rt, md_busy
    );

    modport slave (
        input  flush, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_wa, D_Tnew,
               D_md_use, E_md_start, E_md_div,
        output stall, D_fw_rs, D_fw_rt, E_fw_rs, E_fw_rt, md_busy
    );

endinterface

// File: rtl/hazard_fwd_ctrl_md_busy_ctr.sv
// HI/LO unit busy counter: loads the mult or div latency on start and
// counts down to zero; busy while nonzero.
module hazard_fwd_ctrl_md_busy_ctr #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic div_i,
    output logic busy_o
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A new start reloads even if a previous operation is still counting.
    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy_o = (count_q != '0);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Stall and forwarding-select generator for the 5-stage MIPS core, driven
// by destination tags that shadow the E/M/W pipeline registers.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    hazard_fwd_ctrl_if.slave  hz
);

    e_tag_t    eTag_q, eTag_d;
    reg_addr_t mWa_q, mWa_d;
    tnew_t     mTnew_q, mTnew_d;
    reg_addr_t wWa_q, wWa_d;
    logic      mdBusy;
    logic      stallD;

    // A consumer stalls when its operand is produced later than it is needed.
    always_comb begin
        stallD = 1'b0;
        if (rawHazard(hz.D_rs, hz.D_Tuse_rs, eTag_q.wa, eTag_q.tnew) ||
            rawHazard(hz.D_rs, hz.D_Tuse_rs, mWa_q, mTnew_q)         ||
            rawHazard(hz.D_rt, hz.D_Tuse_rt, eTag_q.wa, eTag_q.tnew) ||
            rawHazard(hz.D_rt, hz.D_Tuse_rt, mWa_q, mTnew_q)) begin
            stallD = 1'b1;
        end
        if (hz.D_md_use && (mdBusy || hz.E_md_start)) begin
            stallD = 1'b1;
        end
    end

    // W keeps advancing on flush: the instruction there has already committed.
    always_comb begin
        eTag_d  = '0;
        mWa_d   = '0;
        mTnew_d = '0;
        wWa_d   = mWa_q;
        if (!(stallD || hz.flush)) begin
            eTag_d = '{rs: hz.D_rs, rt: hz.D_rt, wa: hz.D_wa, tnew: hz.D_Tnew};
        end
        if (!hz.flush) begin
            mWa_d   = eTag_q.wa;
            mTnew_d = (eTag_q.tnew == '0) ? '0 : eTag_q.tnew - tnew_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eTag_q  <= '0;
            mWa_q   <= '0;
            mTnew_q <= '0;
            wWa_q   <= '0;
        end else begin
            eTag_q  <= eTag_d;
            mWa_q   <= mWa_d;
            mTnew_q <= mTnew_d;
            wWa_q   <= wWa_d;
        end
    end

    hazard_fwd_ctrl_md_busy_ctr #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_ctr (
        .clk     (clk),
        .reset   (reset),
        .start_i (hz.E_md_start),
        .div_i   (hz.E_md_div),
        .busy_o  (mdBusy)
    );

    assign hz.stall   = stallD;
    assign hz.md_busy = mdBusy;
    assign hz.D_fw_rs = fwdSelect(hz.D_rs, mWa_q, mTnew_q, wWa_q);
    assign hz.D_fw_rt = fwdSelect(hz.D_rt, mWa_q, mTnew_q, wWa_q);
    assign hz.E_fw_rs = fwdSelect(eTag_q.rs, mWa_q, mTnew_q, wWa_q);
    assign hz.E_fw_rt = fwdSelect(eTag_q.rt, mWa_q, mTnew_q, wWa_q);

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed pipeline scenarios with
// literal expectations, then randomized traffic against a timestamp-based model.
module tb_hazard_fwd_ctrl;
    import hazard_fwd_ctrl_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_fwd_ctrl_if hzIf ();

    hazard_fwd_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hzIf)
    );

    typedef struct packed {
        logic       rst;
        logic       flush;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuseRs;
        logic [1:0] tuseRt;
        logic [4:0] wa;
        logic [1:0] tnew;
        logic       mdUse;
        logic       mdStart;
        logic       mdDiv;
    } stim_t;

    // An in-flight instruction; ready is the absolute cycle its result exists.
    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wa;
        int         ready;
    } slot_t;

    slot_t pipe [3];
    int    cyc       = 0;
    int    mdEnd     = 0;
    bit    modelLive = 1'b0;
    int    checks    = 0;
    int    errors    = 0;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int remTnew(input slot_t s);
        return (s.ready > cyc) ? s.ready - cyc : 0;
    endfunction

    function automatic bit srcHazard(input logic [4:0] a, input logic [1:0] tuse);
        if (a == 5'd0) return 1'b0;
        if (pipe[0].wa == a && int'(tuse) < remTnew(pipe[0])) return 1'b1;
        if (pipe[1].wa == a && int'(tuse) < remTnew(pipe[1])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit modelStall();
        bit mdBusy;
        mdBusy = (cyc < mdEnd);
        return srcHazard(hzIf.D_rs, hzIf.D_Tuse_rs) || srcHazard(hzIf.D_rt, hzIf.D_Tuse_rt) ||
               (hzIf.D_md_use && (mdBusy || hzIf.E_md_start));
    endfunction

    function automatic logic [1:0] modelFwd(input logic [4:0] a);
        if (a == 5'd0) return 2'b00;
        if (pipe[1].wa == a && remTnew(pipe[1]) == 0) return 2'b10;
        if (pipe[2].wa == a) return 2'b01;
        return 2'b00;
    endfunction

    function automatic slot_t bubble();
        slot_t s;
        s.rs = '0; s.rt = '0; s.wa = '0; s.ready = 0;
        return s;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = bubble();
    end

    // Reference model advances on every rising edge from the applied inputs.
    always @(posedge clk) begin
        bit st;
        st = modelStall();
        cyc++;
        if (reset) begin
            for (int i = 0; i < 3; i++) pipe[i] = bubble();
            mdEnd     = 0;
            modelLive = 1'b1;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = hzIf.flush ? bubble() : pipe[0];
            if (st || hzIf.flush) begin
                pipe[0] = bubble();
            end else begin
                pipe[0].rs    = hzIf.D_rs;
                pipe[0].rt    = hzIf.D_rt;
                pipe[0].wa    = hzIf.D_wa;
                pipe[0].ready = cyc + int'(hzIf.D_Tnew);
            end
            if (hzIf.E_md_start) mdEnd = cyc + (hzIf.E_md_div ? DIV_N : MULT_N);
        end
    end

    // Every cycle after the first reset edge, all outputs are compared.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("stall",   8'(hzIf.stall),   8'(modelStall()));
            checkOutput("md_busy", 8'(hzIf.md_busy), 8'(cyc < mdEnd));
            checkOutput("D_fw_rs", 8'(hzIf.D_fw_rs), 8'(modelFwd(hzIf.D_rs)));
            checkOutput("D_fw_rt", 8'(hzIf.D_fw_rt), 8'(modelFwd(hzIf.D_rt)));
            checkOutput("E_fw_rs", 8'(hzIf.E_fw_rs), 8'(modelFwd(pipe[0].rs)));
            checkOutput("E_fw_rt", 8'(hzIf.E_fw_rt), 8'(modelFwd(pipe[0].rt)));
        end
    end

    task automatic applyStimulus(input stim_t s);
        reset           = s.rst;
        hzIf.flush      = s.flush;
        hzIf.D_rs       = s.rs;
        hzIf.D_rt       = s.rt;
        hzIf.D_Tuse_rs  = s.tuseRs;
        hzIf.D_Tuse_rt  = s.tuseRt;
        hzIf.D_wa       = s.wa;
        hzIf.D_Tnew     = s.tnew;
        hzIf.D_md_use   = s.mdUse;
        hzIf.E_md_start = s.mdStart;
        hzIf.E_md_div   = s.mdDiv;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s        = '0;
        s.tuseRs = TUSE_NONE;
        s.tuseRt = TUSE_NONE;
        return s;
    endfunction

    initial begin
        stim_t s;
        int    stallCycles;
        int    busyCycles;

        s = idleStim();
        s.rst = 1'b1;
        applyStimulus(s);
        repeat (2) stepCycle();
        s.rst = 1'b0;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("resetStall", 8'(hzIf.stall),   8'd0);
        checkOutput("resetBusy",  8'(hzIf.md_busy), 8'd0);
        checkOutput("resetEfwRs", 8'(hzIf.E_fw_rs), 8'd0);

        // lw $1 then addu $2,$1,$3
        s = idleStim(); s.wa = 5'd1; s.tnew = 2'd2; s.tuseRs = 2'd1;
        applyStimulus(s); stepCycle();
        s = idleStim(); s.rs = 5'd1; s.tuseRs = 2'd1; s.rt = 5'd3; s.tuseRt = 2'd1;
        s.wa = 5'd2; s.tnew = 2'd1;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("lwUseStall", 8'(hzIf.stall), 8'd1);
        stepCycle();
        @(negedge clk);
        checkOutput("lwUseRelease", 8'(hzIf.stall),   8'd0);
        checkOutput("lwUseDfwRs",   8'(hzIf.D_fw_rs), 8'd0);
        stepCycle();
        applyStimulus(idleStim());
        @(negedge clk);
        checkOutput("lwFwdW", 8'(hzIf.E_fw_rs), 8'd1);

        // addu $1 then beq $1
        s = idleStim(); s.wa = 5'd1; s.tnew = 2'd1;
        applyStimulus(s); stepCycle();
        s = idleStim(); s.rs = 5'd1; s.tuseRs = 2'd0;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("beqStall", 8'(hzIf.stall), 8'd1);
        stepCycle();
        @(negedge clk);
        checkOutput("beqRelease", 8'(hzIf.stall),   8'd0);
        checkOutput("beqFwdM",    8'(hzIf.D_fw_rs), 8'd2);
        stepCycle();

        // $1 written in both M (ready) and W: M must win; $0 never forwards
        s = idleStim(); s.wa = 5'd1; s.tnew = 2'd1;
        applyStimulus(s); stepCycle();
        applyStimulus(s); stepCycle();
        s = idleStim(); s.rs = 5'd1; s.tuseRs = 2'd1;
        applyStimulus(s); stepCycle();
        applyStimulus(idleStim());
        @(negedge clk);
        checkOutput("mPriority", 8'(hzIf.E_fw_rs), 8'd2);
        checkOutput("zeroAddr",  8'(hzIf.D_fw_rs), 8'd0);

        // flush with lw in E and M; W still forwards afterwards
        for (int k = 1; k <= 3; k++) begin
            s = idleStim(); s.wa = 5'(k); s.tnew = 2'd2;
            applyStimulus(s); stepCycle();
        end
        s = idleStim(); s.rs = 5'd3; s.tuseRs = 2'd0; s.flush = 1'b1;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("flushCycleStall", 8'(hzIf.stall), 8'd1);
        stepCycle();
        s = idleStim(); s.rs = 5'd2; s.tuseRs = 2'd0; s.rt = 5'd3; s.tuseRt = 2'd0;
        applyStimulus(s);
        @(negedge clk);
        checkOutput("postFlushStall", 8'(hzIf.stall),   8'd0);
        checkOutput("postFlushFwdW",  8'(hzIf.D_fw_rs), 8'd1);
        checkOutput("postFlushNoM",   8'(hzIf.D_fw_rt), 8'd0);
        applyStimulus(idleStim());
        repeat (3) stepCycle();

        // div start then mflo waiting in D
        s = idleStim(); s.mdStart = 1'b1; s.mdDiv = 1'b1; s.mdUse = 1'b1; s.wa = 5'd2; s.tnew = 2'd1;
        applyStimulus(s);
        stallCycles = 0;
        busyCycles  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hzIf.stall === 1'b1)   stallCycles++;
            if (hzIf.md_busy === 1'b1) busyCycles++;
            stepCycle();
            if (i == 0) begin
                s.mdStart = 1'b0;
                applyStimulus(s);
            end
        end
        checkOutput("divStallCycles", 8'(stallCycles), 8'd11);
        checkOutput("divBusyCycles",  8'(busyCycles),  8'd10);

        // reset during an active div with D stalled
        s = idleStim(); s.mdStart = 1'b1; s.mdDiv = 1'b1; s.mdUse = 1'b1; s.rs = 5'd2; s.tuseRs = 2'd0;
        applyStimulus(s); stepCycle();
        s.mdStart = 1'b0;
        applyStimulus(s);
        repeat (2) stepCycle();
        s.rst = 1'b1;
        applyStimulus(s); stepCycle();
        @(negedge clk);
        checkOutput("rstMidBusy",  8'(hzIf.md_busy), 8'd0);
        checkOutput("rstMidStall", 8'(hzIf.stall),   8'd0);
        checkOutput("rstMidDfwRs", 8'(hzIf.D_fw_rs), 8'd0);
        checkOutput("rstMidEfwRs", 8'(hzIf.E_fw_rs), 8'd0);
        s.rst = 1'b0;
        applyStimulus(s); stepCycle();

        // randomized traffic over a small register window to provoke overlaps
        for (int i = 0; i < 3000; i++) begin
            s         = '0;
            s.rst     = ($urandom_range(0, 199) == 0);
            s.flush   = ($urandom_range(0, 15) == 0);
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.tuseRs  = 2'($urandom_range(0, 3));
            s.tuseRt  = 2'($urandom_range(0, 3));
            s.wa      = 5'($urandom_range(0, 3));
            s.tnew    = 2'($urandom_range(0, 3));
            s.mdUse   = ($urandom_range(0, 3) == 0);
            s.mdStart = ($urandom_range(0, 9) == 0);
            s.mdDiv   = 1'($urandom_range(0, 1));
            applyStimulus(s);
            stepCycle();
        end

        applyStimulus(idleStim());
        stepCycle();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Producer side of the forwarding-select protocol used by the operand muxes in D and E. The muxes consume the select; this block drives it, together with the pipeline stall for the 5-stage MIPS core.
- Tracks destination-register tags and Tnew for the E, M and W stages internally, using tag pipeline registers that shadow the datapath.
- Counts down HI/LO multiply/divide latency.
- Emits stall, and the four forwarding selects for D-rs, D-rt, E-rs and E-rt.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu starts in E.
- DIV_CYCLES, 10, busy cycles after a div/divu starts in E.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  exception/eret flush; kills E and M tags.
- D_rs  in  5  rs address of instruction in D.
- D_rt  in  5  rt address of instruction in D.
- D_Tuse_rs  in  2  cycles until rs is needed, counted from D; 3 = unused.
- D_Tuse_rt  in  2  same for rt.
- D_wa  in  5  destination register of D instruction; 0 = none.
- D_Tnew  in  2  cycles after entering E until the result exists.
- D_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_md_start  in  1  mult or div begins this cycle in E.
- E_md_div  in  1  qualifies E_md_start: 1 = div, 0 = mult.
- stall  out  1  freeze PC and F/D register; bubble into E.
- D_fw_rs  out  2  select for D-stage rs mux.
- D_fw_rt  out  2  select for D-stage rt mux.
- E_fw_rs  out  2  select for E-stage rs mux.
- E_fw_rt  out  2  select for E-stage rt mux.
- md_busy  out  1  HI/LO unit busy.

Behaviour:
- Select encoding on all four fw outputs: 2'b10 = M-stage result, 2'b01 = W-stage result, 2'b00 = register-file / pipeline value. 2'b11 is never driven.
- Tag registers:
  - E: E_rs, E_rt, E_wa, E_Tnew.
  - M: M_wa, M_Tnew.
  - W: W_wa.
  - All of them clear to 0 on reset.
- Each rising clk without reset:
  - E tags <= D inputs, or a bubble (all zero) when stall=1 or flush=1.
  - M_wa <= E_wa; M_Tnew <= (E_Tnew==0) ? 0 : E_Tnew-1. Both become 0 when flush=1.
  - W_wa <= M_wa. W is unaffected by flush, because the instruction in W commits.
- Forwarding is combinational from the tags, for any address a with a != 0:
  - If M_wa==a and M_Tnew==0, select 2'b10.
  - Else if W_wa==a, select 2'b01.
  - Else 2'b00.
  - M has priority over W.
  - D_fw_* use D_rs/D_rt as a; E_fw_* use E_rs/E_rt.
  - Address 0 always selects 2'b00.
- Stall, combinational; stall=1 if any of the following holds:
  - (D_rs!=0, D_rs==E_wa, D_Tuse_rs < E_Tnew)
  - (D_rs!=0, D_rs==M_wa, D_Tuse_rs < M_Tnew)
  - the same two terms for rt
  - D_md_use and (md_busy or E_md_start).
- md counter (4+ bits wide enough for DIV_CYCLES):
  - Reset clears it to 0.
  - On E_md_start, load DIV_CYCLES or MULT_CYCLES. Start has priority over decrement.
  - Otherwise decrement while nonzero; hold at 0.
  - md_busy = (count != 0), registered from the counter.
  - Flush does not clear the counter, because an issued mult/div completes.
- Simultaneous stall and flush: the E bubble is produced either way; no double effect.
- Reset mid-operation: all tags and the counter zero on the next edge. stall=0 and all fw=2'b00 from the cycle after reset asserts.
- Single-cycle combinational paths only from tags and D inputs to outputs. No latency is added to the selects.

Decomposition:
- Shared package holds the FW_NONE, FW_W and FW_M select constants, the TUSE_NONE=3 constant, and the Tnew width.
- One sub-module is natural: md_busy_ctr (parameterised countdown with load and priority start).

Test Plan:
- lw $1 followed by addu $2,$1,$3 (D_Tuse_rs=1, E_Tnew=2) -> stall=1 for exactly 1 cycle. Next cycle E_fw_rs=2'b01 once lw reaches W.
- addu $1 (Tnew=1) followed by beq $1 (Tuse=0) -> cycle 1 stall=1. Cycle 2 stall=0 with D_fw_rs=2'b10.
- $1 written by the instructions in both M (Tnew=0) and W -> E_fw_rs=2'b10 (M priority). Writes to $0 -> 2'b00.
- E_md_start with E_md_div=1, then mflo in D -> stall held for 11 cycles (start cycle plus DIV_CYCLES=10). md_busy falls after exactly 10 cycles.
- flush while lw sits in E and M -> next cycle E_wa=M_wa=0, stall=0, no M forward. W tag still forwards (2'b01).
- reset asserted during an active div with stalled D -> next cycle md_busy=0, stall=0, all fw=2'b00.
